multicycle_control_unit: RTL

- Upstream sequencer for the multi-cycle RV32I core. A Moore/Mealy FSM steps each instruction through IF, ID, EX, MEM and WB.
- It drives all datapath enables and mux selects.
- It decides whether the ALU control stage decodes opcode/funct3/funct7 or is forced to ADD (address and branch-target computation).
- It also sequences multi-cycle memory access and the ECALL halt.

---
 rtl/multicycle_control_unit_if.sv | 43 ++++
 rtl/multicycle_control_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit_if
// Description : Control bundle between the multi-cycle RV32I sequencer and
//               its datapath. Decode and status inputs come from the
//               datapath; enables and mux selects go back to it.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if;
  logic [6:0] opcode;
  logic       bcond;
  logic       x17_is_ten;

  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       alu_force_add;
  logic [1:0] pc_source;
  logic       is_halted;

  // Control unit side: reads decode/status, drives enables and selects
  modport master (
    input  opcode, bcond, x17_is_ten,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_force_add, pc_source,
           is_halted
  );

  // Datapath side
  modport slave (
    output opcode, bcond, x17_is_ten,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_force_add, pc_source,
           is_halted
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : IF/ID/EX/MEM/WB sequencer for a multi-cycle RV32I core.
//               Drives every datapath enable and select, stretches IF and
//               MEM over MEM_LATENCY cycles and parks in HALT on ECALL with
//               x17 == 10.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  multicycle_control_unit_if.master     ctl
);

  localparam int                CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_PLUS4  = 2'b10;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;

  logic       pc_write_c, i_or_d_c, mem_read_c, mem_write_c, ir_write_c;
  logic       reg_write_c, alu_src_a_c, alu_force_add_c, is_halted_c;
  logic [1:0] mem_to_reg_c, alu_src_b_c, pc_source_c;

  logic is_load, is_store, is_known;

  assign cnt_last = (cnt == CNT_LAST);
  assign is_load  = (ctl.opcode == OP_LOAD);
  assign is_store = (ctl.opcode == OP_STORE);
  assign is_known = (ctl.opcode == OP_R)      || (ctl.opcode == OP_I)     ||
                    is_load                   || is_store                 ||
                    (ctl.opcode == OP_BRANCH) || (ctl.opcode == OP_JAL)   ||
                    (ctl.opcode == OP_JALR);

  // State register and wait counter; counter restarts on every transition
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IF;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        cnt <= '0;
      else if (state == S_IF || state == S_MEM)
        cnt <= cnt + CNT_W'(1);
      else
        cnt <= '0;
    end
  end

  // Next-state and control outputs (BRANCH pc_source is Mealy on bcond)
  always_comb begin
    state_next      = state;
    pc_write_c      = 1'b0;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    mem_to_reg_c    = 2'b00;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = 2'b00;
    alu_force_add_c = 1'b0;
    pc_source_c     = PC_ALU;
    is_halted_c     = 1'b0;

    case (state)
      S_IF: begin
        mem_read_c = 1'b1;
        if (cnt_last) begin
          ir_write_c = 1'b1;
          state_next = S_ID;
        end
      end

      S_ID: begin
        // PC+imm is computed here so a taken branch can use ALUOut in EX
        alu_src_b_c     = 2'b01;
        alu_force_add_c = 1'b1;
        if (ctl.opcode == OP_ECALL && ctl.x17_is_ten) begin
          state_next = S_HALT;
        end else if (ctl.opcode == OP_ECALL || !is_known) begin
          pc_write_c  = 1'b1;
          pc_source_c = PC_PLUS4;
          state_next  = S_IF;
        end else begin
          state_next = S_EX;
        end
      end

      S_EX: begin
        state_next = S_IF;
        case (ctl.opcode)
          OP_R: begin
            alu_src_a_c = 1'b1;
            state_next  = S_WB;
          end
          OP_I: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'b01;
            state_next  = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a_c     = 1'b1;
            alu_src_b_c     = 2'b01;
            alu_force_add_c = 1'b1;
            state_next      = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a_c = 1'b1;
            pc_write_c  = 1'b1;
            pc_source_c = ctl.bcond ? PC_ALUOUT : PC_PLUS4;
          end
          OP_JAL, OP_JALR: begin
            alu_src_a_c     = (ctl.opcode == OP_JALR);
            alu_src_b_c     = 2'b01;
            alu_force_add_c = 1'b1;
            pc_write_c      = 1'b1;
            pc_source_c     = PC_ALU;
            reg_write_c     = 1'b1;
            mem_to_reg_c    = 2'b10;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        i_or_d_c    = 1'b1;
        mem_read_c  = is_load;
        mem_write_c = is_store;
        if (cnt_last) begin
          if (is_load) begin
            state_next = S_WB;
          end else begin
            pc_write_c  = is_store;
            pc_source_c = PC_PLUS4;
            state_next  = S_IF;
          end
        end
      end

      S_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = is_load ? 2'b01 : 2'b00;
        pc_write_c   = 1'b1;
        pc_source_c  = PC_PLUS4;
        state_next   = S_IF;
      end

      S_HALT: begin
        is_halted_c = 1'b1;
      end

      default: state_next = S_IF;
    endcase
  end

  // Write enables and strobes are held off for as long as reset is low
  assign ctl.pc_write      = pc_write_c  & reset_n;
  assign ctl.ir_write      = ir_write_c  & reset_n;
  assign ctl.reg_write     = reg_write_c & reset_n;
  assign ctl.mem_read      = mem_read_c  & reset_n;
  assign ctl.mem_write     = mem_write_c & reset_n;
  assign ctl.i_or_d        = i_or_d_c;
  assign ctl.mem_to_reg    = mem_to_reg_c;
  assign ctl.alu_src_a     = alu_src_a_c;
  assign ctl.alu_src_b     = alu_src_b_c;
  assign ctl.alu_force_add = alu_force_add_c;
  assign ctl.pc_source     = pc_source_c;
  assign ctl.is_halted     = is_halted_c;

endmodule
`default_nettype wire
